adc_spi_responder: RTL and testbench

- Synthesizable model of the on-board 8-channel, 12-bit serial ADC, clocked directly by the SPI serial clock.
- Receives a 3-bit channel address on din and returns 12-bit samples on dout in 16-clock frames.
- Used as the far end of the ADC interface for FPGA loopback and bench checks of the ADC reader.
- Sample values come from parallel inputs driven by test logic.

---
 rtl/adc_spi_responder.sv | 84 ++++++++
 tb/tb_adc_spi_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI-clocked 8-channel 12-bit ADC model answering 16-clock address/sample frames.
// Optional ADC_RESP_TEST_PATTERN_EN adds test_mode and a frame counter pattern source.
module adc_spi_responder #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic                     CS_n,
    input  logic                     din,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
`ifdef ADC_RESP_TEST_PATTERN_EN
    input  logic                     test_mode,
`endif
    output logic                     dout,
    output logic [2:0]               cur_ch,
    output logic                     frame_done,
    output logic                     addr_err
);
    localparam logic [3:0] NCH = 4'(NUM_CH);

    if (DATA_W != 12 || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_cfg
        $error("adc_spi_responder: DATA_W must be 12 and NUM_CH within 1..8");
    end

    logic [3:0]        bit_cnt;
    logic [2:0]        addr_shift;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] ch_sel;
    logic [DATA_W-1:0] next_sample;

    assign addr_err = {1'b0, cur_ch} >= NCH;

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (cur_ch == 3'(i)) ch_sel = ch_data[i*DATA_W +: DATA_W];
    end

`ifdef ADC_RESP_TEST_PATTERN_EN
    logic [8:0] frame_cnt;
    assign next_sample = test_mode ? {cur_ch, frame_cnt} : (addr_err ? '0 : ch_sel);

    always_ff @(posedge sclk or posedge rst)
        if (rst) frame_cnt <= '0;
        else if (!CS_n && bit_cnt == 4'd15) frame_cnt <= frame_cnt + 9'd1;
`else
    assign next_sample = addr_err ? '0 : ch_sel;
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            addr_shift <= '0;
            cur_ch     <= '0;
            sample     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= !CS_n && bit_cnt == 4'd15;
            if (CS_n) begin
                // an aborted frame leaves no partial address behind
                bit_cnt    <= '0;
                addr_shift <= '0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                case (bit_cnt)
                    4'd2: addr_shift[2] <= din;
                    4'd3: begin
                        addr_shift[1] <= din;
                        sample        <= next_sample;
                    end
                    4'd4: addr_shift[0] <= din;
                    4'd15: cur_ch <= addr_shift;
                    default: ;
                endcase
            end
        end
    end

    // bit_cnt already holds the reader's upcoming count at this negedge
    always_ff @(negedge sclk or posedge rst)
        if (rst) dout <= 1'b0;
        else dout <= (CS_n || bit_cnt < 4'd4) ? 1'b0 : sample[4'd15 - bit_cnt];
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed frame-level checks of adc_spi_responder (8-channel and 3-channel instances).
module tb_adc_spi_responder;
    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        CS_n = 1'b1;
    logic        din = 1'b0;
    logic [95:0] ch_data;
    logic [35:0] ch_data3;
    logic        dout, frame_done, addr_err;
    logic        dout3, frame_done3, addr_err3;
    logic [2:0]  cur_ch, cur_ch3;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] ch_tab [8] = '{12'hABC, 12'h123, 12'h5A5, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777};

    always #5 sclk = ~sclk;
    assign ch_data3 = ch_data[35:0];

    adc_spi_responder #(.NUM_CH(8), .DATA_W(12)) dut (
        .sclk(sclk), .rst(rst), .CS_n(CS_n), .din(din), .ch_data(ch_data),
`ifdef ADC_RESP_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .dout(dout), .cur_ch(cur_ch), .frame_done(frame_done), .addr_err(addr_err)
    );

    adc_spi_responder #(.NUM_CH(3), .DATA_W(12)) dut3 (
        .sclk(sclk), .rst(rst), .CS_n(CS_n), .din(din), .ch_data(ch_data3),
`ifdef ADC_RESP_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .dout(dout3), .cur_ch(cur_ch3), .frame_done(frame_done3), .addr_err(addr_err3)
    );

    task automatic frame(input logic [2:0] a, output logic [15:0] b, output logic [15:0] b3, output int fd);
        fd = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge sclk); #2;
            CS_n = 1'b0;
            din = (k >= 2 && k <= 4) ? a[4-k] : 1'b0;
            b[15-k] = dout;
            b3[15-k] = dout3;
            @(posedge sclk); #1;
            fd += int'(frame_done);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = ch_tab[i];
        rst = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        checks += 5;
        if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got %b exp 0", dout); end
        if (cur_ch !== 3'd0) begin failures++; $display("FAIL reset_cur_ch got %0d exp 0", cur_ch); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
        if (addr_err3 !== 1'b0) begin failures++; $display("FAIL reset_addr_err3 got %b exp 0", addr_err3); end
        @(negedge sclk); #2;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] b, b3;
        int fd;
        frame(3'd1, b, b3, fd);
        checks += 3;
        if (b !== 16'h0ABC) begin failures++; $display("FAIL basic_f0_data got %h exp 0abc", b); end
        if (fd != 1) begin failures++; $display("FAIL basic_f0_done got %0d exp 1", fd); end
        if (cur_ch !== 3'd1) begin failures++; $display("FAIL basic_cur_ch got %0d exp 1", cur_ch); end
        frame(3'd0, b, b3, fd);
        checks += 2;
        if (b !== 16'h0123) begin failures++; $display("FAIL basic_f1_data got %h exp 0123", b); end
        if (cur_ch !== 3'd0) begin failures++; $display("FAIL basic_f1_cur_ch got %0d exp 0", cur_ch); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] addrs [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        logic [2:0] prev = 3'd0;
        logic [15:0] b, b3;
        int fd;
        for (int i = 0; i < 6; i++) begin
            frame(addrs[i], b, b3, fd);
            checks += 2;
            if (b !== {4'h0, ch_tab[prev]}) begin failures++; $display("FAIL b2b_data[%0d] got %h exp %h", i, b, {4'h0, ch_tab[prev]}); end
            if (fd != 1) begin failures++; $display("FAIL b2b_done[%0d] got %0d exp 1", i, fd); end
            prev = addrs[i];
        end
    endtask

    task automatic test_addr_err;
        logic [15:0] b, b3;
        int fd;
        frame(3'd5, b, b3, fd);
        checks += 3;
        if (addr_err3 !== 1'b1) begin failures++; $display("FAIL aerr_set got %b exp 1", addr_err3); end
        if (cur_ch3 !== 3'd5) begin failures++; $display("FAIL aerr_cur_ch3 got %0d exp 5", cur_ch3); end
        if (addr_err !== 1'b0) begin failures++; $display("FAIL aerr_8ch got %b exp 0", addr_err); end
        frame(3'd1, b, b3, fd);
        checks += 4;
        if (b3 !== 16'h0000) begin failures++; $display("FAIL aerr_data3 got %h exp 0000", b3); end
        if (b !== 16'h0555) begin failures++; $display("FAIL aerr_data8 got %h exp 0555", b); end
        if (addr_err3 !== 1'b0) begin failures++; $display("FAIL aerr_clear got %b exp 0", addr_err3); end
        if (cur_ch3 !== 3'd1) begin failures++; $display("FAIL aerr_cur_ch3_valid got %0d exp 1", cur_ch3); end
    endtask

    task automatic test_abort;
        logic [15:0] b, b3;
        int fd;
        frame(3'd2, b, b3, fd);
        fd = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge sclk); #2;
            din = 1'b0;
            @(posedge sclk); #1;
            fd += int'(frame_done);
        end
        @(negedge sclk); #2;
        CS_n = 1'b1;
        @(posedge sclk); #1;
        fd += int'(frame_done);
        for (int k = 0; k < 3; k++) begin
            @(negedge sclk); #2;
            checks++;
            if (dout !== 1'b0) begin failures++; $display("FAIL abort_dout[%0d] got %b exp 0", k, dout); end
            @(posedge sclk); #1;
            fd += int'(frame_done);
        end
        checks += 2;
        if (fd != 0) begin failures++; $display("FAIL abort_done got %0d exp 0", fd); end
        if (cur_ch !== 3'd2) begin failures++; $display("FAIL abort_cur_ch got %0d exp 2", cur_ch); end
        frame(3'd1, b, b3, fd);
        checks += 3;
        if (b !== 16'h05A5) begin failures++; $display("FAIL abort_next_data got %h exp 05a5", b); end
        if (fd != 1) begin failures++; $display("FAIL abort_next_done got %0d exp 1", fd); end
        if (cur_ch !== 3'd1) begin failures++; $display("FAIL abort_next_cur_ch got %0d exp 1", cur_ch); end
    endtask

    task automatic test_mid_reset;
        logic [15:0] b, b3;
        int fd;
        for (int k = 0; k < 7; k++) begin
            @(negedge sclk); #2;
            din = (k >= 2 && k <= 4) ? 1'b1 : 1'b0;
            @(posedge sclk);
        end
        @(negedge sclk); #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (dout !== 1'b0) begin failures++; $display("FAIL rst_dout got %b exp 0", dout); end
        if (cur_ch !== 3'd0) begin failures++; $display("FAIL rst_cur_ch got %0d exp 0", cur_ch); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
        @(negedge sclk); #2;
        rst = 1'b0;
        CS_n = 1'b1;
        frame(3'd4, b, b3, fd);
        checks += 2;
        if (b !== 16'h0ABC) begin failures++; $display("FAIL rst_next_data got %h exp 0abc", b); end
        if (cur_ch !== 3'd4) begin failures++; $display("FAIL rst_next_cur_ch got %0d exp 4", cur_ch); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_addr_err;
        test_abort;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
